// File: rtl/is_uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART controller block family.
// arb_state_t : lock/drain state machine of the TX arbiter.
// UART_BYTE_W : width of one byte on every requester and on the UART TX port.
package is_pkg_uart_controller;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/is_uart_rr_pick.sv
// Combinational round-robin priority pick.
// Returns the first asserted bit of valid_i at or after index ptr_i, searching
// upward and wrapping modulo N_REQ (N_REQ need not be a power of two).
// Ports:
//   valid_i  in   N_REQ           request vector
//   ptr_i    in   $clog2(N_REQ)   highest-priority index, must be < N_REQ
//   grant_o  out  N_REQ           one-hot winner, 0 when nothing valid
//   idx_o    out  $clog2(N_REQ)   binary index of the winner
//   any_o    out  1               at least one bit of valid_i set
module is_uart_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit holds ptr + k (at most 2*N_REQ-2) before the wrap.
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            cand = sum[PW-1:0];
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/is_uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters.
// Round-robin grant that stays locked to one owner for a whole packet (until a
// byte with req_last_i), a single output byte register driving the UART TX
// handshake, and a watchdog that releases a lock whose owner has gone quiet.
// Ports:
//   clk_i            in   1              system clock
//   rst_i            in   1              asynchronous reset, active-high
//   req_valid_i      in   N_REQ          requester i has a byte
//   req_data_i       in   N_REQ*8        byte of requester i at [8i+7:8i]
//   req_last_i       in   N_REQ          byte of requester i ends its packet
//   req_ready_o      out  N_REQ          requester i may hand over a byte now
//   uart_tx_rdy_t_o  out  1              byte offered to UART (held until taken)
//   uart_tx_data_o   out  8              offered byte
//   uart_tx_rdy_r_i  in   1              UART idle, takes byte when both rdy high
//   grant_o          out  N_REQ          one-hot current owner, 0 when idle
//   busy_o           out  1              packet lock held or byte pending
//   timeout_o        out  1              1-cycle pulse on forced release
module is_uart_tx_arbiter
    import is_pkg_uart_controller::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [N_REQ*UART_BYTE_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]               req_last_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic                           uart_tx_rdy_t_o,
    output logic [UART_BYTE_W-1:0]         uart_tx_data_o,
    input  logic                           uart_tx_rdy_r_i,
    output logic [N_REQ-1:0]               grant_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] IDX_MAX  = PW'(N_REQ - 1);

    arb_state_t             state_q,    state_d;
    logic [N_REQ-1:0]       grant_q,    grant_d;
    logic [PW-1:0]          owner_q,    owner_d;
    logic [PW-1:0]          rr_q,       rr_d;
    logic                   out_full_q, out_full_d;
    logic [UART_BYTE_W-1:0] out_data_q, out_data_d;
    logic [TW-1:0]          tcnt_q,     tcnt_d;
    logic                   timeout_q,  timeout_d;

    logic [N_REQ-1:0]       pick_grant;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;

    logic                   uart_take;
    logic                   own_valid;
    logic                   own_last;
    logic [UART_BYTE_W-1:0] own_data;
    logic [PW-1:0]          owner_succ;
    logic                   ready_ok;
    logic                   accept;

    is_uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Handshake terms seen from the current owner.
    always_comb begin
        uart_take  = out_full_q & uart_tx_rdy_r_i;
        own_valid  = req_valid_i[owner_q];
        own_last   = req_last_i[owner_q];
        own_data   = req_data_i[int'(owner_q)*UART_BYTE_W +: UART_BYTE_W];
        owner_succ = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
        // Ready also when the UART drains the register this same cycle, so a
        // continuously ready UART sees one byte per cycle with no bubble.
        ready_ok   = (state_q == ARB_LOCK) & (~out_full_q | uart_take);
        accept     = ready_ok & own_valid;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        tcnt_d     = tcnt_q;
        timeout_d  = 1'b0;

        // Output byte register: a reload wins over a plain drain.
        if (accept) begin
            out_data_d = own_data;
            out_full_d = 1'b1;
        end else if (uart_take) begin
            out_full_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                tcnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (accept) begin
                    tcnt_d = '0;
                    // A last byte takes precedence over a watchdog expiry.
                    if (own_last) begin
                        rr_d    = owner_succ;
                        state_d = ARB_DRAIN;
                    end
                end else if (!own_valid) begin
                    if (tcnt_q == TCNT_MAX) begin
                        timeout_d = 1'b1;
                        rr_d      = owner_succ;
                        state_d   = ARB_DRAIN;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ARB_DRAIN: begin
                // Leave as soon as the register is empty or empties now.
                if (!out_full_q || uart_take) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
            tcnt_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
            tcnt_q     <= tcnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_ready_o     = ready_ok ? grant_q : '0;
    assign uart_tx_rdy_t_o = out_full_q;
    assign uart_tx_data_o  = out_data_q;
    assign grant_o         = grant_q;
    assign busy_o          = (state_q != ARB_IDLE) | out_full_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_is_uart_tx_arbiter.sv
// Directed bench for is_uart_tx_arbiter (N_REQ=4, TIMEOUT=8).
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next edge. Bytes taken by the UART are logged just before each edge.
module tb_is_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [N_REQ-1:0]     req_valid_i = '0;
    logic [N_REQ*8-1:0]   req_data_i  = '0;
    logic [N_REQ-1:0]     req_last_i  = '0;
    logic [N_REQ-1:0]     req_ready_o;
    logic                 uart_tx_rdy_t_o;
    logic [7:0]           uart_tx_data_o;
    logic                 uart_tx_rdy_r_i = 1'b1;
    logic [N_REQ-1:0]     grant_o;
    logic                 busy_o;
    logic                 timeout_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] uart_log [$];

    is_uart_tx_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .uart_tx_rdy_t_o (uart_tx_rdy_t_o),
        .uart_tx_data_o  (uart_tx_data_o),
        .uart_tx_rdy_r_i (uart_tx_rdy_r_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (!rst_i && uart_tx_rdy_t_o && uart_tx_rdy_r_i) begin
            uart_log.push_back(uart_tx_data_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid_i[i]      = v;
        req_data_i[i*8 +: 8] = d;
        req_last_i[i]       = l;
    endtask

    task automatic wait_grant(input string tag, input logic [N_REQ-1:0] exp);
        int n;
        n = 0;
        while (grant_o !== exp && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(grant_o), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic chk_log(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_len"}, 32'(uart_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < uart_log.size()) begin
                chk($sformatf("%s_b%0d", tag, i), 32'(uart_log[i]), 32'(exp[i]));
            end
        end
        uart_log.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_rdy_t", 32'(uart_tx_rdy_t_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_to",    32'(timeout_o), 32'd0);
        rst_i = 1'b0;
        tick();
        $display("txn reset: done");

        // Single owner, 3-byte packet, UART always ready
        set_req(0, 1'b1, 8'h11, 1'b0);
        #1;
        chk("one_idle_ready", 32'(req_ready_o), 32'd0);
        chk("one_idle_grant", 32'(grant_o), 32'd0);
        tick();
        chk("one_lock_grant", 32'(grant_o), 32'b0001);
        chk("one_lock_ready", 32'(req_ready_o), 32'b0001);
        tick();
        set_req(0, 1'b1, 8'h22, 1'b0);
        #1;
        chk("one_b0_rdy_t", 32'(uart_tx_rdy_t_o), 32'd1);
        chk("one_b0_data",  32'(uart_tx_data_o), 32'h11);
        chk("one_b0_ready", 32'(req_ready_o), 32'b0001);
        tick();
        set_req(0, 1'b1, 8'h33, 1'b1);
        #1;
        chk("one_b1_data", 32'(uart_tx_data_o), 32'h22);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("one_b2_data",    32'(uart_tx_data_o), 32'h33);
        chk("one_drain_grant", 32'(grant_o), 32'b0001);
        chk("one_drain_ready", 32'(req_ready_o), 32'd0);
        chk("one_drain_busy",  32'(busy_o), 32'd1);
        tick();
        chk("one_end_grant", 32'(grant_o), 32'd0);
        chk("one_end_busy",  32'(busy_o), 32'd0);
        chk_log("one", '{8'h11, 8'h22, 8'h33});
        $display("txn single_owner: 3 bytes");

        // Reset mid-packet: rr pointer is 1 here, byte held pending
        uart_tx_rdy_r_i = 1'b0;
        set_req(2, 1'b1, 8'h40, 1'b0);
        wait_grant("mid_grant", 4'b0100);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("mid_pending", 32'(uart_tx_rdy_t_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant_o), 32'd0);
        chk("mid_rst_rdy_t", 32'(uart_tx_rdy_t_o), 32'd0);
        chk("mid_rst_data",  32'(uart_tx_data_o), 32'd0);
        chk("mid_rst_busy",  32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
        tick();
        rst_i = 1'b0;
        uart_tx_rdy_r_i = 1'b1;
        tick();
        tick();
        chk_log("mid", '{});
        $display("txn reset_mid_packet: done");

        // Fairness: all valid, 1-byte packets; first pick proves rr reset to 0
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        end
        for (int p = 0; p < 5; p++) begin
            logic [N_REQ-1:0] exp_g;
            exp_g = '0;
            exp_g[p % N_REQ] = 1'b1;
            wait_grant($sformatf("fair_grant%0d", p), exp_g);
            chk($sformatf("fair_ready%0d", p), 32'(req_ready_o), 32'(exp_g));
            tick();
            if (p == 4) begin
                req_valid_i = '0;
                req_last_i  = '0;
            end
            wait_grant($sformatf("fair_release%0d", p), '0);
            $display("txn fairness: packet %0d owner %0d", p, p % N_REQ);
        end
        wait_idle("fair_idle");
        chk_log("fair", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0});

        // Lock: req1 mid-packet, req2 waiting (rr pointer is 1)
        set_req(1, 1'b1, 8'h51, 1'b0);
        set_req(2, 1'b1, 8'h62, 1'b1);
        wait_grant("lock_grant1", 4'b0010);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lock_hold_grant%0d", c), 32'(grant_o), 32'b0010);
            chk($sformatf("lock_hold_ready%0d", c), 32'(req_ready_o & 4'b0100), 32'd0);
            tick();
        end
        set_req(1, 1'b1, 8'h52, 1'b1);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_grant("lock_grant2", 4'b0100);
        tick();
        set_req(2, 1'b0, 8'h00, 1'b0);
        wait_idle("lock_idle");
        chk_log("lock", '{8'h51, 8'h52, 8'h62});
        $display("txn lock: req1 packet before req2");

        // Backpressure: UART not ready for 10 cycles (rr pointer is 3)
        uart_tx_rdy_r_i = 1'b0;
        set_req(3, 1'b1, 8'h71, 1'b0);
        wait_grant("bp_grant", 4'b1000);
        chk("bp_ready0", 32'(req_ready_o), 32'b1000);
        tick();
        set_req(3, 1'b1, 8'h72, 1'b1);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("bp_rdy_t%0d", c), 32'(uart_tx_rdy_t_o), 32'd1);
            chk($sformatf("bp_data%0d", c),  32'(uart_tx_data_o), 32'h71);
            chk($sformatf("bp_ready%0d", c), 32'(req_ready_o), 32'd0);
            tick();
        end
        uart_tx_rdy_r_i = 1'b1;
        #1;
        chk("bp_ready_resume", 32'(req_ready_o), 32'b1000);
        tick();
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
        chk("bp_data2", 32'(uart_tx_data_o), 32'h72);
        wait_idle("bp_idle");
        chk_log("bp", '{8'h71, 8'h72});
        $display("txn backpressure: 10 stall cycles, no loss");

        // Timeout: req3 sends one non-last byte then idles (rr pointer is 0)
        set_req(3, 1'b1, 8'h81, 1'b0);
        wait_grant("to_grant", 4'b1000);
        tick();
        set_req(3, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h90, 1'b1);
        for (int c = 0; c < TIMEOUT; c++) begin
            #1;
            chk($sformatf("to_quiet%0d", c), 32'(timeout_o), 32'd0);
            chk($sformatf("to_held%0d", c),  32'(grant_o), 32'b1000);
            tick();
        end
        chk("to_pulse",       32'(timeout_o), 32'd1);
        chk("to_drain_grant", 32'(grant_o), 32'b1000);
        tick();
        chk("to_pulse_end", 32'(timeout_o), 32'd0);
        chk("to_idle_grant", 32'(grant_o), 32'd0);
        tick();
        chk("to_next_grant", 32'(grant_o), 32'b0001);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_idle("to_idle");
        chk_log("to", '{8'h81, 8'h90});
        $display("txn timeout: forced release, grant to req0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
